ofs_plat_prim_rw_burst_arbiter: RTL and testbench

OFS_PLAT_PRIM_RW_BURST_ARBITER -- requirements
Module: ofs_plat_prim_rw_burst_arbiter

---
 rtl/ofs_plat_prim_rw_arb_pkg.sv | 47 ++++
 rtl/ofs_plat_prim_rw_burst_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ofs_plat_prim_rw_burst_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_plat_prim_rw_arb_pkg.sv
// Shared types and the idle-state channel selection rule for the
// read/write burst arbiter.
package ofs_plat_prim_rw_arb_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } t_rw_arb_state;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } t_rw_arb_ch;

    // Pick the channel to serve while no write burst is in flight.
    // A lone requester always wins; with both requesting, an unambiguous
    // fairness hint decides, otherwise the previous loser gets its turn.
    // With nobody requesting the answer is irrelevant, so CH0 is returned.
    function automatic t_rw_arb_ch rw_arb_pick(
        input logic       ch0_valid,
        input logic       ch1_valid,
        input logic       favor_ch0,
        input logic       favor_ch1,
        input t_rw_arb_ch last_winner
    );
        t_rw_arb_ch pick;
        if (ch0_valid && !ch1_valid) begin
            pick = CH0;
        end else if (!ch0_valid && ch1_valid) begin
            pick = CH1;
        end else if (ch0_valid && ch1_valid) begin
            if (favor_ch0 && !favor_ch1) begin
                pick = CH0;
            end else if (favor_ch1 && !favor_ch0) begin
                pick = CH1;
            end else if (last_winner == CH0) begin
                pick = CH1;
            end else begin
                pick = CH0;
            end
        end else begin
            pick = CH0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_rw_burst_arbiter.sv
// Merges a read request channel (one handshake per burst) and a write
// beat channel (one handshake per beat) into a single registered output
// stream. Write bursts are never interleaved with reads; fairness hints
// from an external burstcount tracker steer ties while idle.
module ofs_plat_prim_rw_burst_arbiter
    import ofs_plat_prim_rw_arb_pkg::*;
#(
    parameter int BURST_CNT_WIDTH = 7,
    parameter int DATA_WIDTH      = 512
)(
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ch0_valid,
    output logic                       ch0_ready,
    input  logic [BURST_CNT_WIDTH-1:0] ch0_burstcount,

    input  logic                       ch1_valid,
    output logic                       ch1_ready,
    input  logic [BURST_CNT_WIDTH-1:0] ch1_burstcount,
    input  logic [DATA_WIDTH-1:0]      ch1_data,

    input  logic                       favor_ch0,
    input  logic                       favor_ch1,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_is_write,
    output logic [BURST_CNT_WIDTH-1:0] out_burstcount,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_sop,
    output logic                       out_eop,

    output logic                       ch0_grant_valid,
    output logic [BURST_CNT_WIDTH-1:0] ch0_grant_burstcount,
    output logic                       ch1_grant_valid,
    output logic [BURST_CNT_WIDTH-1:0] ch1_grant_burstcount
);

    localparam logic [BURST_CNT_WIDTH-1:0] BC_ZERO = {BURST_CNT_WIDTH{1'b0}};
    localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE  = {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};

    t_rw_arb_state              state_q;
    t_rw_arb_ch                 last_winner_q;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q;

    logic                       out_valid_q;
    logic                       out_is_write_q;
    logic [BURST_CNT_WIDTH-1:0] out_burstcount_q;
    logic [DATA_WIDTH-1:0]      out_data_q;
    logic                       out_sop_q;
    logic                       out_eop_q;

    logic                       ch0_grant_valid_q;
    logic [BURST_CNT_WIDTH-1:0] ch0_grant_bc_q;
    logic                       ch1_grant_valid_q;
    logic [BURST_CNT_WIDTH-1:0] ch1_grant_bc_q;

    logic                       free_s;
    t_rw_arb_ch                 sel_s;
    logic                       ch0_ready_s;
    logic                       ch1_ready_s;
    logic                       rd_acc_s;
    logic                       wr_acc_s;
    logic                       wr_sop_s;

    // Stage availability, channel selection, ready generation and accept strobes.
    always_comb begin
        free_s      = !out_valid_q || out_ready;
        sel_s       = rw_arb_pick(ch0_valid, ch1_valid, favor_ch0, favor_ch1, last_winner_q);
        ch0_ready_s = 1'b0;
        ch1_ready_s = 1'b0;
        if (reset) begin
            ch0_ready_s = 1'b0;
            ch1_ready_s = 1'b0;
        end else if (state_q == WR_BURST) begin
            // Mid-burst only the write channel may advance; hints are ignored.
            ch0_ready_s = 1'b0;
            ch1_ready_s = free_s;
        end else begin
            ch0_ready_s = free_s && (sel_s == CH0);
            ch1_ready_s = free_s && (sel_s == CH1);
        end
        rd_acc_s = ch0_valid && ch0_ready_s;
        wr_acc_s = ch1_valid && ch1_ready_s;
        wr_sop_s = wr_acc_s && (state_q == IDLE);
    end

    // Burst state machine, fairness memory, output stage and grant pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            last_winner_q     <= CH1;
            beats_left_q      <= BC_ZERO;
            out_valid_q       <= 1'b0;
            out_is_write_q    <= 1'b0;
            out_burstcount_q  <= BC_ZERO;
            out_data_q        <= {DATA_WIDTH{1'b0}};
            out_sop_q         <= 1'b0;
            out_eop_q         <= 1'b0;
            ch0_grant_valid_q <= 1'b0;
            ch0_grant_bc_q    <= BC_ZERO;
            ch1_grant_valid_q <= 1'b0;
            ch1_grant_bc_q    <= BC_ZERO;
        end else begin
            // Grants pulse once per read and once per write burst (SOP only).
            ch0_grant_valid_q <= rd_acc_s;
            ch1_grant_valid_q <= wr_sop_s;
            if (rd_acc_s) begin
                ch0_grant_bc_q <= ch0_burstcount;
            end
            if (wr_sop_s) begin
                ch1_grant_bc_q <= ch1_burstcount;
            end

            if (rd_acc_s) begin
                last_winner_q <= CH0;
            end else if (wr_sop_s) begin
                last_winner_q <= CH1;
            end

            if (rd_acc_s) begin
                // A read is a single-handshake burst; payload is left untouched.
                out_valid_q      <= 1'b1;
                out_is_write_q   <= 1'b0;
                out_sop_q        <= 1'b1;
                out_eop_q        <= 1'b1;
                out_burstcount_q <= ch0_burstcount;
            end else if (wr_acc_s) begin
                out_valid_q    <= 1'b1;
                out_is_write_q <= 1'b1;
                out_data_q     <= ch1_data;
                case (state_q)
                    IDLE: begin
                        out_sop_q        <= 1'b1;
                        out_eop_q        <= (ch1_burstcount == BC_ZERO);
                        out_burstcount_q <= ch1_burstcount;
                        if (ch1_burstcount != BC_ZERO) begin
                            state_q      <= WR_BURST;
                            beats_left_q <= ch1_burstcount;
                        end
                    end
                    WR_BURST: begin
                        // Burstcount stays at the SOP value for every beat.
                        out_sop_q    <= 1'b0;
                        out_eop_q    <= (beats_left_q == BC_ONE);
                        beats_left_q <= beats_left_q - BC_ONE;
                        if (beats_left_q == BC_ONE) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign ch0_ready            = ch0_ready_s;
    assign ch1_ready            = ch1_ready_s;
    assign out_valid            = out_valid_q;
    assign out_is_write         = out_is_write_q;
    assign out_burstcount       = out_burstcount_q;
    assign out_data             = out_data_q;
    assign out_sop              = out_sop_q;
    assign out_eop              = out_eop_q;
    assign ch0_grant_valid      = ch0_grant_valid_q;
    assign ch0_grant_burstcount = ch0_grant_bc_q;
    assign ch1_grant_valid      = ch1_grant_valid_q;
    assign ch1_grant_burstcount = ch1_grant_bc_q;

endmodule

// File: tb/tb_ofs_plat_prim_rw_burst_arbiter.sv
// Bench for the read/write burst arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ofs_plat_prim_rw_burst_arbiter;

    localparam int BCW = 7;
    localparam int DW  = 512;

    logic           clk = 1'b0;
    logic           reset;
    logic           ch0_valid, ch0_ready;
    logic [BCW-1:0] ch0_burstcount;
    logic           ch1_valid, ch1_ready;
    logic [BCW-1:0] ch1_burstcount;
    logic [DW-1:0]  ch1_data;
    logic           favor_ch0, favor_ch1;
    logic           out_valid, out_ready, out_is_write, out_sop, out_eop;
    logic [BCW-1:0] out_burstcount;
    logic [DW-1:0]  out_data;
    logic           ch0_grant_valid, ch1_grant_valid;
    logic [BCW-1:0] ch0_grant_burstcount, ch1_grant_burstcount;

    int total = 0;
    int bad   = 0;

    ofs_plat_prim_rw_burst_arbiter #(.BURST_CNT_WIDTH(BCW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_burstcount(ch0_burstcount),
        .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_burstcount(ch1_burstcount),
        .ch1_data(ch1_data),
        .favor_ch0(favor_ch0), .favor_ch1(favor_ch1),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_write(out_is_write),
        .out_burstcount(out_burstcount), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .ch0_grant_valid(ch0_grant_valid), .ch0_grant_burstcount(ch0_grant_burstcount),
        .ch1_grant_valid(ch1_grant_valid), .ch1_grant_burstcount(ch1_grant_burstcount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Expected output register contents and burst progress.
    logic          m_ov, m_wr, m_sop, m_eop, m_g0v, m_g1v;
    int            m_bc, m_g0bc, m_g1bc, m_burst_bc;
    logic [DW-1:0] m_data;
    int            m_rem;   // write beats still owed in the current burst
    int            m_last;  // 0: read won last, 1: write won last

    // Per-cycle check of DUT against model, then advance model at the clock edge.
    always begin
        logic          free, pick0, r0, r1, a0, a1;
        logic          n_ov, n_wr, n_sop, n_eop, n_g0v, n_g1v;
        int            n_bc, n_g0bc, n_g1bc, n_burst_bc, n_rem, n_last;
        logic [DW-1:0] n_data;
        @(negedge clk);
        if (reset) begin
            m_ov = 1'b0; m_wr = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
            m_g0v = 1'b0; m_g1v = 1'b0; m_bc = 0; m_g0bc = 0; m_g1bc = 0;
            m_burst_bc = 0; m_data = '0; m_rem = 0; m_last = 1;
            chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
            chk("rst_sop_eop_wr", DW'({out_sop, out_eop, out_is_write}), DW'(3'b000));
            chk("rst_grants", DW'({ch0_grant_valid, ch1_grant_valid}), DW'(2'b00));
            chk("rst_readies", DW'({ch0_ready, ch1_ready}), DW'(2'b00));
        end else begin
            chk("out_valid", DW'(out_valid), DW'(m_ov));
            if (m_ov) begin
                chk("out_is_write", DW'(out_is_write), DW'(m_wr));
                chk("out_sop", DW'(out_sop), DW'(m_sop));
                chk("out_eop", DW'(out_eop), DW'(m_eop));
                chk("out_burstcount", DW'(out_burstcount), DW'(m_bc));
                chk("out_data", out_data, m_data);
            end
            chk("g0_valid", DW'(ch0_grant_valid), DW'(m_g0v));
            chk("g1_valid", DW'(ch1_grant_valid), DW'(m_g1v));
            if (m_g0v) chk("g0_bc", DW'(ch0_grant_burstcount), DW'(m_g0bc));
            if (m_g1v) chk("g1_bc", DW'(ch1_grant_burstcount), DW'(m_g1bc));

            free = !m_ov || out_ready;
            if (ch0_valid && !ch1_valid)       pick0 = 1'b1;
            else if (ch1_valid && !ch0_valid)  pick0 = 1'b0;
            else if (!ch0_valid && !ch1_valid) pick0 = 1'b1;
            else if (favor_ch0 && !favor_ch1)  pick0 = 1'b1;
            else if (favor_ch1 && !favor_ch0)  pick0 = 1'b0;
            else                               pick0 = (m_last == 1);
            if (m_rem > 0) begin
                r0 = 1'b0; r1 = free;
            end else begin
                r0 = free && pick0; r1 = free && !pick0;
            end
            if (ch0_valid) chk("ch0_ready", DW'(ch0_ready), DW'(r0));
            if (ch1_valid) chk("ch1_ready", DW'(ch1_ready), DW'(r1));
            a0 = ch0_valid && r0;
            a1 = ch1_valid && r1;

            n_ov = m_ov; n_wr = m_wr; n_sop = m_sop; n_eop = m_eop; n_bc = m_bc;
            n_data = m_data; n_rem = m_rem; n_last = m_last; n_burst_bc = m_burst_bc;
            n_g0v = a0; n_g0bc = m_g0bc; n_g1v = 1'b0; n_g1bc = m_g1bc;
            if (a0) begin
                n_ov = 1'b1; n_wr = 1'b0; n_sop = 1'b1; n_eop = 1'b1;
                n_bc = int'(ch0_burstcount); n_g0bc = int'(ch0_burstcount); n_last = 0;
            end else if (a1) begin
                n_ov = 1'b1; n_wr = 1'b1; n_data = ch1_data;
                if (m_rem == 0) begin
                    n_sop = 1'b1; n_bc = int'(ch1_burstcount);
                    n_rem = int'(ch1_burstcount); n_eop = (n_rem == 0);
                    n_burst_bc = n_bc; n_g1v = 1'b1; n_g1bc = n_bc; n_last = 1;
                end else begin
                    n_sop = 1'b0; n_bc = m_burst_bc; n_rem = m_rem - 1;
                    n_eop = (n_rem == 0);
                end
            end else if (out_ready) begin
                n_ov = 1'b0;
            end
            @(posedge clk);
            m_ov = n_ov; m_wr = n_wr; m_sop = n_sop; m_eop = n_eop; m_bc = n_bc;
            m_data = n_data; m_rem = n_rem; m_last = n_last; m_burst_bc = n_burst_bc;
            m_g0v = n_g0v; m_g0bc = n_g0bc; m_g1v = n_g1v; m_g1bc = n_g1bc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < DW / 32; i++) ch1_data[i*32 +: 32] = $urandom();
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int wr_beats, sops, eops, g1_pulses, g1bc_seen, c0r;
        reset = 1'b1; ch0_valid = 1'b0; ch1_valid = 1'b0;
        ch0_burstcount = '0; ch1_burstcount = '0; ch1_data = '0;
        favor_ch0 = 1'b0; favor_ch1 = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // First tie goes to ch0, then alternation.
        reset = 1'b0; ch0_valid = 1'b1; ch1_valid = 1'b1; rand_data();
        @(negedge clk);
        chk("tie1_ch0_ready", DW'(ch0_ready), DW'(1'b1));
        chk("tie1_ch1_ready", DW'(ch1_ready), DW'(1'b0));
        @(negedge clk);
        chk("tie2_read_out", DW'({out_valid, out_is_write, ch0_grant_valid}), DW'(3'b101));
        chk("tie2_ch1_ready", DW'(ch1_ready), DW'(1'b1));
        @(negedge clk);
        chk("tie3_write_out", DW'({out_is_write, out_sop, out_eop, ch1_grant_valid}), DW'(4'b1111));
        chk("tie3_ch0_ready", DW'(ch0_ready), DW'(1'b1));

        // Hint toward ch1 holds ch0 off every arbitration.
        step(); favor_ch1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("favor1_ch0_blocked", DW'(ch0_ready), DW'(1'b0));
            step(); rand_data();
        end

        // Four-beat write with ch0 waiting.
        ch0_valid = 1'b0; ch1_valid = 1'b0; favor_ch1 = 1'b0;
        repeat (2) step();
        ch0_valid = 1'b1; ch1_valid = 1'b1; ch1_burstcount = 7'd3; favor_ch1 = 1'b1;
        wr_beats = 0; sops = 0; eops = 0; g1_pulses = 0; g1bc_seen = 0; c0r = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && out_is_write) begin
                wr_beats++;
                if (out_sop) sops++;
                if (out_eop) eops++;
            end
            if (ch1_grant_valid) begin
                g1_pulses++;
                g1bc_seen = int'(ch1_grant_burstcount);
            end
            if (i < 4 && ch0_ready) c0r++;
            step(); rand_data(); ch1_burstcount = 7'($urandom_range(0, 127));
            if (i == 3) begin
                ch1_valid = 1'b0; favor_ch1 = 1'b0;
            end
        end
        chk("burst4_beats", DW'(wr_beats), DW'(4));
        chk("burst4_sops", DW'(sops), DW'(1));
        chk("burst4_eops", DW'(eops), DW'(1));
        chk("burst4_g1_pulses", DW'(g1_pulses), DW'(1));
        chk("burst4_g1_bc", DW'(g1bc_seen), DW'(3));
        chk("burst4_ch0_held", DW'(c0r), DW'(0));

        // Back-to-back reads with burstcounts 0..7.
        ch0_burstcount = 7'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            ch0_burstcount = 7'(k + 1);
            if (k == 7) ch0_valid = 1'b0;
            @(negedge clk);
            chk("rd_seq_grant", DW'({ch0_grant_valid, ch0_grant_burstcount}), DW'({1'b1, 7'(k)}));
            chk("rd_seq_out_bc", DW'({out_valid, out_burstcount}), DW'({1'b1, 7'(k)}));
        end

        // Reset after two of four beats abandons the burst.
        step();
        ch1_valid = 1'b1; ch1_burstcount = 7'd3; rand_data();
        step(); rand_data();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("midrst_ch1_ready", DW'(ch1_ready), DW'(1'b0));
        step();
        reset = 1'b0; ch1_burstcount = 7'd0; rand_data();
        @(negedge clk);
        chk("postrst_ch1_ready", DW'(ch1_ready), DW'(1'b1));
        step(); ch1_valid = 1'b0;
        @(negedge clk);
        chk("postrst_sop", DW'({out_valid, out_is_write, out_sop, out_eop}), DW'(4'b1111));

        // Output stall mid-burst.
        step();
        ch1_valid = 1'b1; ch1_burstcount = 7'd3; rand_data();
        step(); rand_data();
        step(); rand_data(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", DW'({ch0_ready, ch1_ready}), DW'(2'b00));
            chk("stall_mid_beat", DW'({out_valid, out_sop, out_eop}), DW'(3'b100));
            step();
        end
        out_ready = 1'b1;
        step(); rand_data();
        step(); ch1_valid = 1'b0;
        @(negedge clk);
        chk("stall_last_beat", DW'({out_valid, out_is_write, out_eop}), DW'(3'b111));

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset     = ($urandom_range(0, 399) == 0);
            ch0_valid = $urandom_range(0, 1) == 1;
            ch1_valid = $urandom_range(0, 9) < 7;
            ch0_burstcount = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                                         : 7'($urandom_range(0, 3));
            ch1_burstcount = ($urandom_range(0, 19) == 0) ? 7'($urandom_range(0, 31))
                                                          : 7'($urandom_range(0, 3));
            favor_ch0 = $urandom_range(0, 1) == 1;
            favor_ch1 = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            rand_data();
        end
        step(); reset = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
